// File: rtl/vpu_mem_responder.sv
// Memory-side responder for the VPU operand/result handshake: scratchpad, operand reads, result write, host port.
// Optional macro VPU_RESP_ADDR_CHK_EN adds sticky err_addr (VPU address vs decoded address cross-check).
module vpu_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 13,
  parameter int INST_ADDR  = 5,
  parameter int OP_W       = 4,
  parameter int DEPTH      = 256,
  parameter int RD_LAT     = 2,
  parameter int WR_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst,
  input  logic              op_go,
  output logic              op_busy,
  output logic              op_done,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_c,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  input  logic [DATA_W-1:0] data_c,
  input  logic              vpu_done,
  output logic              mem_rdy,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic              host_en,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              err_oob,
  output logic              err_timeout
`ifdef VPU_RESP_ADDR_CHK_EN
  ,
  output logic              err_addr
`endif
);

  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW      = OP_W + 4*INST_ADDR;
  localparam int CNT_MAX = (RD_LAT > WR_TIMEOUT) ? RD_LAT : WR_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] KICK   = 3'd1;
  localparam logic [2:0] WAIT_A = 3'd2;
  localparam logic [2:0] RDY_A  = 3'd3;
  localparam logic [2:0] WAIT_B = 3'd4;
  localparam logic [2:0] RDY_B  = 3'd5;
  localparam logic [2:0] WRITE  = 3'd6;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [IW-1:0]        inst_q;
  logic [INST_ADDR-1:0] fa, fb, fk;
  logic [ADDR_W-1:0]    rd_a, rd_b, rd_addr, wr_addr;
  logic [DATA_W-1:0]    rd_word, wr_data;
  logic                 unary, rd_ok, wr_host, wr_vpu, wr_en, last_wait, unused;

  function automatic logic in_rng(input logic [ADDR_W-1:0] x);
    return {1'b0, x} < LIM;
  endfunction

  // inst is latched at op_go so the decode stays stable for the whole op
  assign fa    = inst_q[OP_W +: INST_ADDR];
  assign fb    = inst_q[OP_W+INST_ADDR +: INST_ADDR];
  assign fk    = inst_q[OP_W+3*INST_ADDR +: INST_ADDR];
  assign unary = inst_q[OP_W-1:0] == OP_W'(2);
  assign rd_a  = ADDR_W'(fa);
  assign rd_b  = (fb == '0 && fk != '0) ? ADDR_W'(fk) : ADDR_W'(fb);

  assign op_busy      = state != IDLE;
  assign mem_rdy      = state == KICK || state == RDY_A || state == RDY_B || state == WRITE;
  assign mem_read_en  = state == WAIT_A || state == RDY_A || state == WAIT_B || state == RDY_B;
  assign mem_write_en = state == WRITE;
  assign last_wait    = cnt == CNT_W'(RD_LAT - 1);

  // one shared read port: host owns it in IDLE, operand fetch otherwise
  assign rd_addr = (state == IDLE) ? host_addr : (state == WAIT_B) ? rd_b : rd_a;
  assign rd_ok   = in_rng(rd_addr);
  assign rd_word = rd_ok ? mem[rd_addr[AW-1:0]] : '0;

  assign wr_host = state == IDLE && host_en && host_we;
  assign wr_vpu  = state == WRITE && vpu_done;
  assign wr_addr = wr_vpu ? addr_c : host_addr;
  assign wr_data = wr_vpu ? data_c : host_wdata;
  assign wr_en   = !rst && (wr_host || wr_vpu) && in_rng(wr_addr);

`ifdef VPU_RESP_ADDR_CHK_EN
  assign unused = ^{inst[31:IW], inst_q[OP_W+2*INST_ADDR +: INST_ADDR]};
`else
  assign unused = ^{inst[31:IW], inst_q[OP_W+2*INST_ADDR +: INST_ADDR], addr_a, addr_b};
`endif

  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr[AW-1:0]] <= wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      inst_q      <= '0;
      data_a      <= '0;
      data_b      <= '0;
      op_done     <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      err_oob     <= 1'b0;
      err_timeout <= 1'b0;
`ifdef VPU_RESP_ADDR_CHK_EN
      err_addr    <= 1'b0;
`endif
    end else begin
      op_done     <= 1'b0;
      host_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (host_en) begin
            if (!in_rng(host_addr)) err_oob <= 1'b1;
            if (!host_we) begin
              host_rvalid <= 1'b1;
              host_rdata  <= rd_word;
            end
          end
          if (op_go) begin
            inst_q <= inst[IW-1:0];
            state  <= KICK;
          end
        end
        KICK: begin
          cnt   <= '0;
          state <= WAIT_A;
        end
        WAIT_A, WAIT_B: begin
          if (last_wait) begin
            if (state == WAIT_A) data_a <= rd_word;
            else                 data_b <= rd_word;
            if (!rd_ok) err_oob <= 1'b1;
            cnt   <= '0;
            state <= (state == WAIT_A) ? RDY_A : RDY_B;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RDY_A: begin
`ifdef VPU_RESP_ADDR_CHK_EN
          if (addr_a != rd_a) err_addr <= 1'b1;
`endif
          cnt   <= '0;
          state <= unary ? WRITE : WAIT_B;
        end
        RDY_B: begin
`ifdef VPU_RESP_ADDR_CHK_EN
          if (addr_b != rd_b) err_addr <= 1'b1;
`endif
          cnt   <= '0;
          state <= WRITE;
        end
        WRITE: begin
          if (vpu_done) begin
            if (!in_rng(addr_c)) err_oob <= 1'b1;
            op_done <= 1'b1;
            state   <= IDLE;
          end else if (cnt == CNT_W'(WR_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vpu_mem_responder.sv
// Bench for vpu_mem_responder: scratchpad model plus handshake schedule derived from latency rules.
module tb_vpu_mem_responder;
  localparam int DW = 32, AWD = 13, DEPTH = 16, RD_LAT = 2, WR_TO = 16;

  logic           clk = 1'b0, rst;
  logic [31:0]    inst;
  logic           op_go, op_busy, op_done, vpu_done;
  logic [AWD-1:0] addr_a, addr_b, addr_c, host_addr;
  logic [DW-1:0]  data_a, data_b, data_c, host_wdata, host_rdata;
  logic           mem_rdy, mem_read_en, mem_write_en;
  logic           host_en, host_we, host_rvalid, err_oob, err_timeout;
`ifdef VPU_RESP_ADDR_CHK_EN
  logic           err_addr;
`endif

  vpu_mem_responder #(.DATA_W(DW), .ADDR_W(AWD), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_TIMEOUT(WR_TO)) dut (
    .clk(clk), .rst(rst), .inst(inst), .op_go(op_go), .op_busy(op_busy), .op_done(op_done),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .data_a(data_a), .data_b(data_b),
    .data_c(data_c), .vpu_done(vpu_done), .mem_rdy(mem_rdy), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .err_oob(err_oob), .err_timeout(err_timeout)
`ifdef VPU_RESP_ADDR_CHK_EN
    , .err_addr(err_addr)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [31:0] mm [DEPTH];
  bit          exp_oob, exp_to, exp_ae;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", t, o, e);
    end
  endtask

  // {mem_rdy, mem_read_en, mem_write_en, op_busy}
  function automatic logic [31:0] st();
    return {28'd0, mem_rdy, mem_read_en, mem_write_en, op_busy};
  endfunction

  function automatic logic [31:0] mexp(input int a);
    return (a < DEPTH) ? mm[a] : 32'd0;
  endfunction

  task automatic chk_err(input string t);
    chk({t, "_err_oob"}, 32'(err_oob), 32'(exp_oob));
    chk({t, "_err_timeout"}, 32'(err_timeout), 32'(exp_to));
`ifdef VPU_RESP_ADDR_CHK_EN
    chk({t, "_err_addr"}, 32'(err_addr), 32'(exp_ae));
`endif
  endtask

  task automatic host_wr(input int a, input logic [31:0] d);
    host_en = 1; host_we = 1; host_addr = AWD'(a); host_wdata = d;
    tick();
    host_en = 0; host_we = 0;
    if (a < DEPTH) mm[a] = d; else exp_oob = 1;
  endtask

  task automatic host_rd(input int a);
    host_en = 1; host_we = 0; host_addr = AWD'(a);
    tick();
    host_en = 0;
    chk("host_rvalid", 32'(host_rvalid), 32'd1);
    chk("host_rdata", host_rdata, mexp(a));
    if (a >= DEPTH) exp_oob = 1;
  endtask

  // One full op as a VPU would see it; done_at = WRITE cycle index that raises vpu_done (-1: never).
  task automatic run_op(input int op, input int a, input int b, input int k, input int c,
                        input logic [31:0] dc, input int done_at, input bit bad_b, input int hr);
    int          rb = (b == 0 && k != 0) ? k : b;
    bit          un = (op == 2);
    bit          fin = 0;
    logic [31:0] ea = mexp(a), eb = mexp(rb);
    inst   = {8'($urandom), 5'(k), 5'(c), 5'(b), 5'(a), 4'(op)};
    addr_a = AWD'(a); addr_b = AWD'(bad_b ? (rb ^ 1) : rb); addr_c = AWD'(c); data_c = dc;
    op_go = 1; host_en = 1; host_we = 0; host_addr = AWD'(hr);
    tick();
    chk("kick", st(), 32'h9);
    chk("go_host_rvalid", 32'(host_rvalid), 32'd1);
    chk("go_host_rdata", host_rdata, mexp(hr));
    if (hr >= DEPTH) exp_oob = 1;
    // stray op_go / vpu_done / host write while busy must all be ignored
    vpu_done = 1; host_we = 1; host_addr = '0; host_wdata = ~mm[0];
    for (int i = 0; i < RD_LAT; i++) begin
      tick();
      if (i == 0) begin vpu_done = 0; op_go = 0; host_we = 0; end
      else host_en = 0;
      chk("wait_a", st(), 32'h5);
      chk("busy_rvalid", 32'(host_rvalid), 32'd0);
    end
    host_en = 0;
    tick();
    chk("rdy_a", st(), 32'hD);
    chk("data_a", data_a, ea);
    if (a >= DEPTH) exp_oob = 1;
    if (!un) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tick();
        chk("wait_b", st(), 32'h5);
      end
      tick();
      chk("rdy_b", st(), 32'hD);
      chk("data_b", data_b, eb);
      if (rb >= DEPTH) exp_oob = 1;
      if (bad_b) exp_ae = 1;
    end
    for (int w = 0; w < WR_TO && !fin; w++) begin
      tick();
      chk("write", st(), 32'hB);
      if (w == done_at) begin vpu_done = 1; fin = 1; end
    end
    tick();
    vpu_done = 0;
    chk("end_idle", st(), 32'h0);
    chk("op_done", 32'(op_done), 32'(fin));
    if (fin) begin
      if (c < DEPTH) mm[c] = dc; else exp_oob = 1;
    end else exp_to = 1;
    chk_err("op");
    tick();
    chk("op_done_pulse", 32'(op_done), 32'd0);
  endtask

  initial begin
    rst = 1; inst = 0; op_go = 0; vpu_done = 0; addr_a = 0; addr_b = 0; addr_c = 0; data_c = 0;
    host_en = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    exp_oob = 0; exp_to = 0; exp_ae = 0;
    tick(); tick();
    rst = 0;
    chk("rst_state", st(), 32'h0);
    chk("rst_op_done", 32'(op_done), 32'd0);
    chk("rst_data_a", data_a, 32'd0);
    chk("rst_data_b", data_b, 32'd0);
    chk("rst_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_rdata", host_rdata, 32'd0);
    chk_err("rst");

    for (int i = 0; i < DEPTH; i++) host_wr(i, $urandom);
    host_wr(3, 32'h11); host_wr(4, 32'h22); host_wr(9, 32'h5);
    host_rd(3); host_rd(4); host_rd($urandom_range(DEPTH-1, 0));
    chk_err("preload");

    run_op(1, 3, 4, 0, 5, $urandom, 2, 0, 6);    // binary a=3 b=4 c=5
    host_rd(5);
    run_op(2, 7, 12, 0, 8, $urandom, 0, 0, 1);   // unary: no operand B phase
    host_rd(8);
    run_op(1, 1, 0, 9, 10, $urandom, 5, 0, 2);   // b=0, const=9 -> operand B from mem[9]
    host_rd(10);
    run_op(3, 6, 0, 0, 11, $urandom, 15, 0, 3);  // b=0, const=0 -> mem[0]; done on last WRITE cycle
    host_rd(11);
    run_op(1, 2, 3, 0, 12, $urandom, -1, 0, 4);  // no vpu_done -> timeout, no write
    host_rd(12);
    run_op(1, 5, 6, 0, 20, $urandom, 1, 1, 7);   // c=20 out of range; VPU addr_b mismatch
    host_rd(4);
    host_wr(20, $urandom);                       // out-of-range host write dropped
    host_rd(4);
    host_rd(20);
    run_op(1, 21, 3, 0, 13, $urandom, 3, 0, 0);  // out-of-range operand A reads 0
    host_rd(13);

    for (int n = 0; n < 6; n++) begin
      int rb;
      rb = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(DEPTH-1, 0);
      run_op($urandom_range(3, 0), $urandom_range(DEPTH-1, 0), rb, $urandom_range(DEPTH-1, 0),
             $urandom_range(DEPTH-1, 0), $urandom, $urandom_range(WR_TO-1, 0), 0,
             $urandom_range(DEPTH-1, 0));
    end

    // reset while in WAIT_B abandons the op and clears sticky errors
    inst = {8'd0, 5'd0, 5'd14, 5'd4, 5'd3, 4'd1};
    addr_a = 3; addr_b = 4; addr_c = 14;
    op_go = 1;
    tick();
    op_go = 0;
    for (int i = 0; i < RD_LAT + 2; i++) tick();
    chk("pre_rst_wait_b", st(), 32'h5);
    rst = 1;
    tick();
    rst = 0;
    exp_oob = 0; exp_to = 0; exp_ae = 0;
    chk("midrst_state", st(), 32'h0);
    chk("midrst_data_a", data_a, 32'd0);
    chk_err("midrst");
    run_op(1, 3, 4, 0, 14, $urandom, 4, 0, 9);

    for (int i = 0; i < DEPTH; i++) host_rd(i);
    chk_err("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
